cc_driver_panel: RTL and testbench

- Driver-side front end for the cruise control controller. It takes raw, bouncing steering-wheel buttons and the brake pedal switch and produces the clean command inputs the controller consumes.
- Per raw line: synchronise, then debounce. Per button: edge-detect into a single-cycle command pulse, with auto-repeat on held accel/coast.
- Brake is a low-latency level path that bypasses debounce.
- Arbitration guarantees at most one command pulse per cycle.

---
 rtl/cc_driver_panel.sv | 185 ++++++++++++++++++
 tb/tb_cc_driver_panel.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cc_driver_panel.sv
// Cruise-control driver panel: synchronises and debounces the steering-wheel buttons into one-hot command pulses, brake as a 2-flop level.
// Press-to-pulse latency 2 + DEBOUNCE_CYCLES + 1 edges; brake 2 edges; no backpressure, gated or losing pulses are dropped.
module cc_driver_panel #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_RATE     = 4,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_set_raw,
  input  logic btn_accel_raw,
  input  logic btn_coast_raw,
  input  logic btn_cancel_raw,
  input  logic btn_resume_raw,
  input  logic brake_raw,
  output logic set,
  output logic accel,
  output logic coast,
  output logic cancel,
  output logic resume,
  output logic brake,
  output logic btn_conflict
);

  localparam int NB    = 5;
  localparam int B_SET = 0;
  localparam int B_ACC = 1;
  localparam int B_CST = 2;
  localparam int B_CAN = 3;
  localparam int B_RES = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_DELAY = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RPT_RATE  = CNT_W'(REPEAT_RATE);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Bit NB of the synchroniser carries the brake switch.
  logic [NB:0]              sync1_q, sync1_d;
  logic [NB:0]              sync2_q, sync2_d;
  logic [NB-1:0]            stable_q, stable_d;
  logic [NB-1:0]            stable_prev_q, stable_prev_d;
  logic [NB-1:0][CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]               state_q, state_d;
  logic                     dir_q, dir_d;
  logic [CNT_W-1:0]         rep_cnt_q, rep_cnt_d;
  logic [NB-1:0]            out_q, out_d;
  logic                     conflict_q, conflict_d;

  logic [NB-1:0] rise;
  logic [NB-1:0] cand;
  logic          brake_lvl;
  logic          both_now;
  logic          both_prev;
  logic          acc_press;
  logic          cst_press;
  logic          held;
  logic          abort;
  logic          rep_pulse;

  always_comb begin
    sync1_d = {brake_raw, btn_resume_raw, btn_cancel_raw, btn_coast_raw,
               btn_accel_raw, btn_set_raw};
    sync2_d = sync1_q;
  end

  always_comb begin
    stable_d      = stable_q;
    stable_prev_d = stable_q;
    for (int i = 0; i < NB; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  always_comb begin
    brake_lvl  = sync2_q[NB];
    rise       = stable_q & ~stable_prev_q;
    both_now   = stable_q[B_ACC] & stable_q[B_CST];
    both_prev  = stable_prev_q[B_ACC] & stable_prev_q[B_CST];
    conflict_d = both_now & ~both_prev;
    acc_press  = rise[B_ACC] & ~both_now & ~brake_lvl;
    cst_press  = rise[B_CST] & ~both_now & ~brake_lvl;
  end

  // Repeat engine: dir_q = 1 means coast is the held direction.
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    rep_cnt_d = rep_cnt_q;
    rep_pulse = 1'b0;
    held      = dir_q ? stable_q[B_CST] : stable_q[B_ACC];
    abort     = ~held | brake_lvl | both_now;
    case (state_q)
      ST_DELAY, ST_REPEAT: begin
        if (abort) begin
          state_d   = ST_IDLE;
          rep_cnt_d = '0;
        end else if (rep_cnt_q == CNT_ONE) begin
          rep_pulse = 1'b1;
          state_d   = ST_REPEAT;
          rep_cnt_d = RPT_RATE;
        end else begin
          rep_cnt_d = rep_cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        rep_cnt_d = '0;
      end
    endcase
    if ((state_d == ST_IDLE) && (acc_press || cst_press)) begin
      state_d   = ST_DELAY;
      dir_d     = cst_press;
      rep_cnt_d = RPT_DELAY;
    end
  end

  always_comb begin
    cand        = '0;
    cand[B_CAN] = rise[B_CAN];
    cand[B_SET] = rise[B_SET] & ~brake_lvl;
    cand[B_RES] = rise[B_RES] & ~brake_lvl;
    cand[B_ACC] = acc_press | (rep_pulse & ~dir_q);
    cand[B_CST] = cst_press | (rep_pulse & dir_q);

    out_d = '0;
    if (cand[B_CAN]) begin
      out_d[B_CAN] = 1'b1;
    end else if (cand[B_SET]) begin
      out_d[B_SET] = 1'b1;
    end else if (cand[B_RES]) begin
      out_d[B_RES] = 1'b1;
    end else if (cand[B_ACC]) begin
      out_d[B_ACC] = 1'b1;
    end else if (cand[B_CST]) begin
      out_d[B_CST] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      db_cnt_q      <= '0;
      state_q       <= ST_IDLE;
      dir_q         <= 1'b0;
      rep_cnt_q     <= '0;
      out_q         <= '0;
      conflict_q    <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_prev_d;
      db_cnt_q      <= db_cnt_d;
      state_q       <= state_d;
      dir_q         <= dir_d;
      rep_cnt_q     <= rep_cnt_d;
      out_q         <= out_d;
      conflict_q    <= conflict_d;
    end
  end

  assign set          = out_q[B_SET];
  assign accel        = out_q[B_ACC];
  assign coast        = out_q[B_CST];
  assign cancel       = out_q[B_CAN];
  assign resume       = out_q[B_RES];
  assign brake        = sync2_q[NB];
  assign btn_conflict = conflict_q;

endmodule

// File: tb/tb_cc_driver_panel.sv
// Directed bench for cc_driver_panel: pulse counts and cycle positions are checked against hand-derived timelines.
module tb_cc_driver_panel;

  logic clk;
  logic reset;
  logic btn_set_raw, btn_accel_raw, btn_coast_raw, btn_cancel_raw, btn_resume_raw;
  logic brake_raw;
  logic set, accel, coast, cancel, resume, brake, btn_conflict;

  int vectors;
  int miscompares;
  int cyc;
  int cnt   [6];
  int first [6];
  int last  [6];
  int first_brk;
  int acc_cyc[$];
  int exp_acc [7];

  cc_driver_panel dut (
    .clk            (clk),
    .reset          (reset),
    .btn_set_raw    (btn_set_raw),
    .btn_accel_raw  (btn_accel_raw),
    .btn_coast_raw  (btn_coast_raw),
    .btn_cancel_raw (btn_cancel_raw),
    .btn_resume_raw (btn_resume_raw),
    .brake_raw      (brake_raw),
    .set            (set),
    .accel          (accel),
    .coast          (coast),
    .cancel         (cancel),
    .resume         (resume),
    .brake          (brake),
    .btn_conflict   (btn_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    cyc = 0;
    for (int b = 0; b < 6; b++) begin
      cnt[b]   = 0;
      first[b] = -1;
      last[b]  = -1;
    end
    first_brk = -1;
    acc_cyc.delete();
  endtask

  // Index order: 0 set, 1 accel, 2 coast, 3 cancel, 4 resume, 5 btn_conflict.
  task automatic run(input int n);
    logic [5:0] obs;
    logic       ok;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cyc++;
      obs = {btn_conflict, resume, cancel, coast, accel, set};
      for (int b = 0; b < 6; b++) begin
        if (obs[b] === 1'b1) begin
          cnt[b]++;
          if (first[b] < 0) first[b] = cyc;
          last[b] = cyc;
        end
      end
      if (accel === 1'b1) acc_cyc.push_back(cyc);
      if (brake === 1'b1 && first_brk < 0) first_brk = cyc;
      ok = ($countones({set, accel, coast, cancel, resume}) <= 1);
      chk("onehot", {31'b0, ok}, 1);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    exp_acc = '{7, 15, 19, 23, 27, 31, 35};
    reset = 1'b0;
    btn_set_raw = 0; btn_accel_raw = 0; btn_coast_raw = 0;
    btn_cancel_raw = 0; btn_resume_raw = 0; brake_raw = 0;
    clr();

    // Reset held for three cycles, then idle with all lines low
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_outs", {25'b0, set, accel, coast, cancel, resume, brake, btn_conflict}, 0);
    end
    reset = 1'b1;
    clr();
    run(20);
    for (int b = 0; b < 6; b++) chk($sformatf("idle_cnt%0d", b), cnt[b], 0);
    chk("idle_brake", {31'b0, brake}, 0);

    // Clean set press: one pulse seven edges later, none while held
    clr();
    btn_set_raw = 1;
    run(57);
    chk("set_cnt", cnt[0], 1);
    chk("set_first", first[0], 7);
    btn_set_raw = 0;
    run(10);
    chk("set_release", cnt[0], 1);

    // Cancel bounce and short glitch are filtered, clean press passes
    clr();
    btn_cancel_raw = 1; run(1);
    btn_cancel_raw = 0; run(1);
    btn_cancel_raw = 1; run(1);
    btn_cancel_raw = 0; run(10);
    btn_cancel_raw = 1; run(3);
    btn_cancel_raw = 0; run(10);
    chk("can_glitch", cnt[3], 0);
    clr();
    btn_cancel_raw = 1; run(10);
    btn_cancel_raw = 0; run(10);
    chk("can_cnt", cnt[3], 1);
    chk("can_first", first[3], 7);

    // Held accel: first pulse, delayed repeat, then steady repeat until stable falls
    clr();
    btn_accel_raw = 1; run(30);
    btn_accel_raw = 0; run(15);
    chk("acc_n", acc_cyc.size(), 7);
    for (int i = 0; i < 7; i++)
      chk($sformatf("acc_t%0d", i), (i < acc_cyc.size()) ? acc_cyc[i] : -1, exp_acc[i]);
    chk("acc_other", cnt[0] + cnt[2] + cnt[3] + cnt[4] + cnt[5], 0);

    // Short coast hold: press pulse plus exactly one delayed repeat
    clr();
    btn_coast_raw = 1; run(10);
    btn_coast_raw = 0; run(15);
    chk("cst_cnt", cnt[2], 2);
    chk("cst_first", first[2], 7);
    chk("cst_last", last[2], 15);
    chk("cst_noacc", cnt[1], 0);

    // Reset mid-repeat clears outputs at once; held button re-arms as a fresh press
    clr();
    btn_accel_raw = 1; run(15);
    chk("mid_acc_hi", {31'b0, accel}, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_outs", {25'b0, set, accel, coast, cancel, resume, brake, btn_conflict}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    clr();
    run(10);
    chk("fresh_first", first[1], 7);
    btn_accel_raw = 0; run(30);
    chk("fresh_cnt", cnt[1], 2);
    chk("fresh_last", last[1], 15);

    // Brake: two-edge level path, gates resume and accel, cancel still passes
    clr();
    brake_raw = 1; run(3);
    chk("brk_lat", first_brk, 2);
    clr();
    btn_resume_raw = 1; run(10);
    btn_resume_raw = 0; run(10);
    btn_accel_raw = 1; run(20);
    btn_accel_raw = 0; run(10);
    chk("brk_res", cnt[4], 0);
    chk("brk_acc", cnt[1], 0);
    clr();
    btn_cancel_raw = 1; run(10);
    btn_cancel_raw = 0; run(10);
    chk("brk_can_cnt", cnt[3], 1);
    chk("brk_can_first", first[3], 7);
    brake_raw = 0; run(3);
    chk("brk_off", {31'b0, brake}, 0);

    // Simultaneous set + cancel: cancel wins, set is lost
    clr();
    btn_set_raw = 1; btn_cancel_raw = 1; run(12);
    btn_set_raw = 0; btn_cancel_raw = 0; run(10);
    chk("arb_can", cnt[3], 1);
    chk("arb_can_first", first[3], 7);
    chk("arb_set", cnt[0], 0);

    // Accel + coast together: single conflict pulse, no direction pulses
    clr();
    btn_accel_raw = 1; btn_coast_raw = 1; run(30);
    btn_accel_raw = 0; btn_coast_raw = 0; run(15);
    chk("conf_cnt", cnt[5], 1);
    chk("conf_first", first[5], 7);
    chk("conf_acc", cnt[1], 0);
    chk("conf_cst", cnt[2], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
